// File: rtl/usb_trans_scheduler.sv
// Round-robin scheduler sharing one USB protocol FSM among NUM_REQ requesters,
// with bounded retry on failure and a watchdog abort for a hung protocol FSM.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate from rr_ptr and grant
// ISSUE | pulse in_trans/out_trans to the protocol FSM
// WAIT  | await success/failure while the watchdog runs
// RESP  | hold the response until the consumer accepts it

module usb_trans_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 2,
  parameter int WATCHDOG  = 4096
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_dir,
  input  logic [NUM_REQ*7-1:0]       req_addr,
  input  logic [NUM_REQ*4-1:0]       req_endp,
  input  logic [NUM_REQ*64-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_ok,
  output logic                       rsp_timeout,
  output logic [63:0]                rsp_data,
  output logic                       pfsm_in_trans,
  output logic                       pfsm_out_trans,
  output logic [6:0]                 pfsm_addr,
  output logic [3:0]                 pfsm_endp,
  output logic [63:0]                pfsm_data,
  output logic                       pfsm_abort,
  input  logic                       pfsm_success,
  input  logic                       pfsm_failure,
  input  logic [63:0]                pfsm_data_in,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WD_W = $clog2(WATCHDOG);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic              cur_dir;
  logic [RC_W-1:0]   retry_cnt;
  logic [WD_W-1:0]   wd_cnt;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   cand;
  logic              sel_dir;
  logic [6:0]        sel_addr;
  logic [3:0]        sel_endp;
  logic [63:0]       sel_data;

  // First valid requester at or after rr_ptr, then mux out its fields.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    sel_dir  = 1'b0;
    sel_addr = '0;
    sel_endp = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == ID_W'(k)) begin
        sel_dir  = req_dir[k];
        sel_addr = req_addr[7*k +: 7];
        sel_endp = req_endp[4*k +: 4];
        sel_data = req_data[64*k +: 64];
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      cur_id         <= '0;
      cur_dir        <= 1'b0;
      retry_cnt      <= '0;
      wd_cnt         <= '0;
      req_grant      <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_ok         <= 1'b0;
      rsp_timeout    <= 1'b0;
      rsp_data       <= '0;
      pfsm_in_trans  <= 1'b0;
      pfsm_out_trans <= 1'b0;
      pfsm_addr      <= '0;
      pfsm_endp      <= '0;
      pfsm_data      <= '0;
      pfsm_abort     <= 1'b0;
    end else begin
      req_grant      <= '0;
      pfsm_in_trans  <= 1'b0;
      pfsm_out_trans <= 1'b0;
      pfsm_abort     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            req_grant[pick_idx] <= 1'b1;
            cur_id    <= pick_idx;
            cur_dir   <= sel_dir;
            pfsm_addr <= sel_addr;
            pfsm_endp <= sel_endp;
            pfsm_data <= sel_data;
            rr_ptr    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            retry_cnt <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          pfsm_in_trans  <= cur_dir;
          pfsm_out_trans <= !cur_dir;
          wd_cnt         <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (pfsm_success) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_ok    <= 1'b1;
            rsp_data  <= cur_dir ? pfsm_data_in : 64'd0;
            state     <= S_RESP;
          end else if (pfsm_failure) begin
            if (retry_cnt < RC_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_id    <= cur_id;
              rsp_ok    <= 1'b0;
              rsp_data  <= '0;
              state     <= S_RESP;
            end
          end else if (wd_cnt == WD_W'(WATCHDOG - 1)) begin
            // Hung protocol FSM: kick it back to Hold and report, no retry.
            pfsm_abort  <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_ok      <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_ok      <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
